// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, the
// bit-period divisor table selected by i_baud, parity modes and clock rate.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int unsigned CLK_HZ = 23040000;

    // Clocks per bit for each i_baud code at CLK_HZ.
    localparam int unsigned BAUD_DIV [8] = '{100, 200, 400, 600, 1200, 2400, 4800, 9600};

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;
`endif

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_MARK = 2'd3
    } parity_e;

endpackage

// File: rtl/uart_fifo.sv
// Small character FIFO with show-ahead read data (head entry is visible on
// rd_data while non-empty; rd_en advances it at the clock edge).
// Writes while full and reads while empty are ignored.
module uart_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: characters enter a FIFO over valid/ready and are
// serialised back-to-back as start + DATA_W data + [parity] + 1/2 stop bits.
// Bit period, bit order, stop count (and parity) are latched at each pop.
// Optional feature macro: UART_TX_PARITY_EN (adds i_parity and PARITY state).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 14
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_baud,
    input  logic              i_msb_first,
    input  logic              i_stop2,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]        i_parity,
`endif
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned BIT_W = $clog2(DATA_W);

    state_e            state;
    state_e            state_nxt;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    logic [DATA_W-1:0] char_rev;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] shreg;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              stop2_q;
    logic              second_stop;

    logic              bit_end;
    logic              data_last;
    logic              stop_last;
    logic              tx_nxt;
    logic              done;

`ifdef UART_TX_PARITY_EN
    logic              par_en_q;
    logic              par_bit_q;
    logic              par_en_nxt;
    logic              par_bit_nxt;
`endif

    uart_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (i_valid),
        .wr_data (i_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_ready   = !fifo_full;
    assign o_busy    = (state != ST_IDLE) || !fifo_empty;
    assign o_done    = done;

    assign bit_end   = (cnt == div_q - DIV_W'(1));
    assign data_last = (bit_cnt == BIT_W'(DATA_W - 1));
    assign stop_last = !stop2_q || second_stop;

    // MSB-first frames are bit-reversed on load so the shifter always emits bit 0.
    always_comb begin
        char_rev = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            char_rev[i] = fifo_rd_data[DATA_W-1-i];
        end
        load_data = i_msb_first ? char_rev : fifo_rd_data;
    end

`ifdef UART_TX_PARITY_EN
    // Parity bit for the head character under the currently selected mode.
    always_comb begin
        par_en_nxt  = 1'b1;
        par_bit_nxt = 1'b1;
        case (parity_e'(i_parity))
            PAR_NONE: par_en_nxt  = 1'b0;
            PAR_EVEN: par_bit_nxt = ^fifo_rd_data;
            PAR_ODD:  par_bit_nxt = ~(^fifo_rd_data);
            default:  par_bit_nxt = 1'b1;
        endcase
    end
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: each non-idle state advances on the last clock of its bit.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && data_last) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end && stop_last) begin
                    state_nxt = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: pop/done strobes and the level o_tx takes after this edge.
    always_comb begin
        pop    = 1'b0;
        done   = 1'b0;
        tx_nxt = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    tx_nxt = 1'b0;
                end
            end
            ST_START: begin
                tx_nxt = bit_end ? shreg[0] : 1'b0;
            end
            ST_DATA: begin
                if (!bit_end) begin
                    tx_nxt = shreg[0];
                end else if (!data_last) begin
                    tx_nxt = shreg[1];
                end else begin
`ifdef UART_TX_PARITY_EN
                    tx_nxt = par_en_q ? par_bit_q : 1'b1;
`else
                    tx_nxt = 1'b1;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_nxt = bit_end ? 1'b1 : par_bit_q;
            end
`endif
            ST_STOP: begin
                if (bit_end && stop_last) begin
                    done = 1'b1;
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        tx_nxt = 1'b0;
                    end
                end
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    // Datapath: frame configuration latched at pop, bit timing and shifting.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_tx        <= 1'b1;
            shreg       <= '0;
            div_q       <= '0;
            cnt         <= '0;
            bit_cnt     <= '0;
            stop2_q     <= 1'b0;
            second_stop <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
`endif
        end else begin
            o_tx <= tx_nxt;
            if (pop) begin
                shreg       <= load_data;
                div_q       <= DIV_W'(BAUD_DIV[i_baud]);
                stop2_q     <= i_stop2;
                cnt         <= '0;
                bit_cnt     <= '0;
                second_stop <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par_en_q    <= par_en_nxt;
                par_bit_q   <= par_bit_nxt;
`endif
            end else if (state != ST_IDLE) begin
                if (bit_end) begin
                    cnt <= '0;
                    if (state == ST_DATA) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                    if (state == ST_STOP) begin
                        second_stop <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frames plus randomized bursts, with the
// expected line computed per frame from its character and configuration.
module tb_uart_tx_fifo;

    localparam int unsigned W = 8;

    typedef struct {
        logic [7:0]  d;
        int unsigned div;
        bit          msb;
        bit          stop2;
        int unsigned par;
    } frame_t;

    int unsigned div_tab [8] = '{100, 200, 400, 600, 1200, 2400, 4800, 9600};

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [2:0] baud;
    logic       msb;
    logic       stop2;
    logic [1:0] par;
    logic       tx;
    logic       busy;
    logic       done;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned cfg_par;

    frame_t      fq [$];
    int unsigned gaps_q [$];
    frame_t      cur;
    bit          in_frame;
    int unsigned cyc, mism, done_pos, done_cnt, gap;
    int unsigned stray_start, stray_done, busy_low, frames_seen;

    uart_tx_fifo #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .DIV_W      (14)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_baud      (baud),
        .i_msb_first (msb),
        .i_stop2     (stop2),
`ifdef UART_TX_PARITY_EN
        .i_parity    (par),
`endif
        .o_tx        (tx),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic par_bit(input frame_t f);
        case (f.par)
            1:       return ^f.d;
            2:       return ~(^f.d);
            default: return 1'b1;
        endcase
    endfunction

    function automatic int unsigned frame_len(input frame_t f);
        return f.div * (1 + W + ((f.par != 0) ? 1 : 0) + (f.stop2 ? 2 : 1));
    endfunction

    // Expected line level at clock c (0-based) of frame f.
    function automatic logic exp_level(input frame_t f, input int unsigned c);
        int unsigned b;
        logic [7:0]  sh;
        b = c / f.div;
        if (b == 0) return 1'b0;
        if (b <= W) begin
            sh = f.msb ? (f.d >> (W - b)) : (f.d >> (b - 1));
            return sh[0];
        end
        if (f.par != 0 && b == W + 1) return par_bit(f);
        return 1'b1;
    endfunction

    // Line monitor: matches each falling start edge to the next queued frame.
    initial begin
        in_frame = 1'b0;
        gap = 0; stray_start = 0; stray_done = 0; busy_low = 0; frames_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 1'b0;
                gap = 0;
            end else begin
                if (!in_frame) begin
                    if (tx == 1'b0) begin
                        if (fq.size() != 0) begin
                            cur = fq.pop_front();
                            in_frame = 1'b1;
                            cyc = 0; mism = 0; done_pos = 0; done_cnt = 0;
                            gaps_q.push_back(gap);
                        end else begin
                            stray_start++;
                        end
                    end else begin
                        gap++;
                    end
                    if (!in_frame && done) stray_done++;
                end
                if (in_frame) begin
                    if (tx !== exp_level(cur, cyc)) mism++;
                    if (!busy) busy_low++;
                    if (done) begin
                        done_cnt++;
                        done_pos = cyc + 1;
                    end
                    cyc++;
                    if (cyc == frame_len(cur)) begin
                        check_eq("frame_line_mismatches", mism, 0);
                        check_eq("frame_done_at", done_pos, frame_len(cur));
                        check_eq("frame_done_count", done_cnt, 1);
                        in_frame = 1'b0;
                        gap = 0;
                        frames_seen++;
                    end
                end
            end
        end
    end

    task automatic set_cfg(input int unsigned b, input bit m, input bit s, input int unsigned p);
        baud  = 3'(b);
        msb   = m;
        stop2 = s;
`ifdef UART_TX_PARITY_EN
        par     = 2'(p);
        cfg_par = p;
`else
        par     = 2'(p);
        cfg_par = 0;
`endif
    endtask

    // Called and returns on a falling edge; records the frame at the handshake edge.
    task automatic push_byte(input logic [7:0] d, output int unsigned waited);
        frame_t f;
        waited = 0;
        data  = d;
        valid = 1'b1;
        while (!ready && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            check_eq("push_ready_timeout", 32'(ready), 1);
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        f.d = d; f.div = div_tab[baud]; f.msb = msb; f.stop2 = stop2; f.par = cfg_par;
        fq.push_back(f);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((busy || in_frame || fq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_tx", 32'(tx), 1);
        check_eq("idle_ready", 32'(ready), 1);
        check_eq("idle_pending_frames", 32'(fq.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned w;
        int unsigned n;
        int unsigned base;
        int unsigned nch;
        logic [7:0]  rd;

        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        valid = 1'b0;
        data  = '0;
        set_cfg(0, 1'b0, 1'b0, 0);

        // Reset state, sampled while reset is held and after release.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_tx", 32'(tx), 1);
            check_eq("rst_ready", 32'(ready), 1);
            check_eq("rst_busy", 32'(busy), 0);
        end
        check_eq("rst_done", 32'(done), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_tx", 32'(tx), 1);
        check_eq("post_rst_busy", 32'(busy), 0);

        // 0x55, 8N1 at 100 clocks/bit; start bit appears one edge after handshake.
        set_cfg(0, 1'b0, 1'b0, 0);
        push_byte(8'h55, w);
        check_eq("latency_pre_tx", 32'(tx), 1);
        check_eq("latency_busy", 32'(busy), 1);
        @(negedge clk);
        check_eq("latency_start_tx", 32'(tx), 0);
        wait_idle(3000);

        // 0xA3 MSB first, two stop bits, 400 clocks/bit: 4400-clock frame.
        set_cfg(2, 1'b1, 1'b1, 0);
        push_byte(8'hA3, w);
        wait_idle(6000);

        // Six back-to-back pushes into a 4-deep FIFO.
        set_cfg(0, 1'b0, 1'b0, 0);
        gaps_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_byte(8'(8'h30 + i), w);
            check_eq("burst_push_wait", w, 0);
        end
        check_eq("burst_ready_low_after_5", 32'(ready), 0);
        push_byte(8'hC6, w);
        check_eq("burst_6th_wait", w, 997);
        check_eq("burst_ready_low_after_6", 32'(ready), 0);
        wait_idle(8000);
        check_eq("burst_frame_count", 32'(gaps_q.size()), 6);
        for (int i = 1; i < 6; i++) begin
            if (i < gaps_q.size()) check_eq("burst_gap", gaps_q[i], 0);
        end

        // Reset in the middle of the second queued frame's data bits.
        set_cfg(0, 1'b0, 1'b0, 0);
        base = frames_seen;
        push_byte(8'h0F, w);
        push_byte(8'h00, w);
        push_byte(8'hFF, w);
        n = 0;
        while (frames_seen < base + 1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_test_first_frame_seen", 32'(frames_seen - base), 1);
        repeat (300) @(negedge clk);
        check_eq("rst_test_mid_frame_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_tx", 32'(tx), 1);
        check_eq("async_rst_ready", 32'(ready), 1);
        check_eq("async_rst_busy", 32'(busy), 0);
        fq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (1500) @(negedge clk);
        check_eq("after_rst_tx", 32'(tx), 1);
        check_eq("after_rst_busy", 32'(busy), 0);
        check_eq("after_rst_no_start", stray_start, 0);

`ifdef UART_TX_PARITY_EN
        // Parity of 0x07 (three ones): odd mode sends 0, even mode sends 1.
        set_cfg(0, 1'b0, 1'b0, 2);
        push_byte(8'h07, w);
        repeat (950) @(negedge clk);
        check_eq("parity_odd_bit", 32'(tx), 0);
        wait_idle(3000);
        set_cfg(0, 1'b0, 1'b0, 1);
        push_byte(8'h07, w);
        repeat (950) @(negedge clk);
        check_eq("parity_even_bit", 32'(tx), 1);
        wait_idle(3000);
`endif

        // Randomized segments; single-character segments also scramble the
        // configuration inputs once the frame has started.
        for (int k = 0; k < 5; k++) begin
            set_cfg($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3));
            nch = $urandom_range(1, 3);
            for (int j = 0; j < int'(nch); j++) begin
                rd = 8'($urandom_range(0, 255));
                push_byte(rd, w);
            end
            if (nch == 1) begin
                repeat (2) @(negedge clk);
                set_cfg($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
            wait_idle(12000);
        end

        check_eq("stray_start", stray_start, 0);
        check_eq("stray_done", stray_done, 0);
        check_eq("busy_low_in_frame", busy_low, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the team's single-character UART transmitter.
- Buffers characters in a small FIFO behind a valid/ready handshake and serialises them back-to-back.
- Supports configurable data width, run-time LSB/MSB order and 1 or 2 stop bits.
- Sits between the command/packet logic and the board TX pin; system clock is 23.04 MHz.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, character buffer entries; power of two, >= 2.
- DIV_W, 14, width of the bit-period counter; must hold the largest divisor (9600).

Ports:
- i_clk  in  1  system clock, 23.04 MHz.
- i_rst  in  1  asynchronous, active-low reset.
- i_data  in  DATA_W  character to send.
- i_valid  in  1  i_data is valid this cycle.
- o_ready  out  1  FIFO can accept; a transfer occurs when i_valid && o_ready at a rising edge.
- i_baud  in  3  bit-period select: 0..7 gives 100, 200, 400, 600, 1200, 2400, 4800, 9600 clocks.
- i_msb_first  in  1  1 = MSB first, 0 = LSB first.
- i_stop2  in  1  1 = two stop bits, 0 = one stop bit.
- o_tx  out  1  serial line, idle high, registered.
- o_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- o_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values: o_tx=1, o_ready=1, o_busy=0, o_done=0. FIFO is emptied, FSM goes to IDLE, all counters are 0.
- Reset mid-frame aborts the frame immediately; o_tx returns to 1 asynchronously with reset.
- FIFO:
  - o_ready = !full; it does not depend on a same-cycle pop (no push-through when full).
  - A push while full cannot occur; i_valid with o_ready=0 is simply held off by the source.
- FSM states: IDLE, START, DATA, STOP. PARITY is present only with the optional feature.
- IDLE:
  - When the FIFO is non-empty: pop, latch the character, latch i_baud divisor / i_msb_first / i_stop2, drive o_tx=0, go to START.
  - Configuration changes mid-frame have no effect until the next pop.
- Latency: handshake at edge N, FIFO empty and FSM idle -> o_tx=0 after edge N+1.
- Every bit lasts exactly DIV clocks, where DIV is the latched divisor. The bit counter counts 0..DIV-1; at DIV-1 it moves to the next bit.
- START -> DATA. DATA shifts out DATA_W bits in the latched order, then goes to STOP (or PARITY when enabled).
- STOP:
  - o_tx=1 for DIV clocks with one stop bit, 2*DIV clocks with two.
  - In the final cycle: pulse o_done.
  - If the FIFO is non-empty, pop in that same cycle and drive o_tx=0 next cycle. There is no idle gap between frames.
  - Otherwise go to IDLE.
- Frame length (8N1, i_baud=0): 10*100 = 1000 clocks from o_tx falling to o_done pulse, inclusive.
- o_busy = (state != IDLE) || !empty.
- Divisor arithmetic is unsigned DIV_W bits; no overflow is possible with the DIV_W default.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Adds input i_parity[1:0]: 0 = none, 1 = even, 2 = odd, 3 = mark (always 1).
  - i_parity is latched at pop.
  - The parity bit is XOR over the DATA_W data bits (inverted for odd), sent for DIV clocks in the PARITY state between DATA and STOP.
- When undefined: no port, no PARITY state, frame = start + data + stop.

Decomposition:
- Package uart_pkg:
  - state enum;
  - baud divisor table constant indexed by i_baud;
  - parity mode enum;
  - CLK_HZ = 23040000.
- Sub-module: uart_fifo (parametrised DATA_W x FIFO_DEPTH, synchronous read/write, full/empty flags, same async reset). Reusable by the receive side.

Test Plan:
- Reset with o_tx sampled during and after reset -> o_tx=1, o_ready=1, o_busy=0 throughout.
- i_baud=0, LSB first, 1 stop, push 0x55 -> line 0,1,0,1,0,1,0,1,0,1, each exactly 100 clocks; o_done pulses once at clock 1000.
- i_msb_first=1, i_stop2=1, i_baud=2, push 0xA3 -> bits 1,0,1,0,0,0,1,1 at 400 clocks each; stop high for 800 clocks; o_done at clock 4400.
- Push 6 characters back-to-back with FIFO_DEPTH=4 -> o_ready drops after the 5th accepted push (one in flight, four buffered), then reasserts as frames drain. Frames are contiguous: next start bit begins the clock after the previous stop ends. Six o_done pulses in order.
- Assert i_rst mid-DATA of the 2nd queued frame -> o_tx=1 immediately, FIFO empty. After release, no residual frame is sent.
- With UART_TX_PARITY_EN, i_parity=2 (odd), push 0x07 -> parity bit 0 inserted before the stop bit. With i_parity=1 (even) -> 1.
